// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared SM3 types, constants and XOR/rotate helpers
package sm3_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        EXPND = 1'b1
    } expnd_st_t;

    localparam int SM3_BLK_WORDS = 16;
    localparam int SM3_ROUNDS    = 64;

    function automatic logic [31:0] sm3_rotl32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] sm3_p1(input logic [31:0] x);
        return x ^ sm3_rotl32(x, 5'd15) ^ sm3_rotl32(x, 5'd23);
    endfunction

endpackage

// File: rtl/sm3_expnd_win.sv
// rtl/sm3_expnd_win.sv - 16x32 sliding window with load-shift and expand-shift ports
module sm3_expnd_win
    import sm3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [31:0] load_d,
    input  logic        expnd_en,
    output logic [31:0] w0,
    output logic [31:0] w4
);

    logic [31:0] win [SM3_BLK_WORDS];
    logic [31:0] w_new;

    // W_{j+16} from the 16 words currently held; win[0] is W_j
    always_comb begin
        w_new = sm3_p1(win[0] ^ win[7] ^ sm3_rotl32(win[13], 5'd15))
              ^ sm3_rotl32(win[3], 5'd7) ^ win[10];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SM3_BLK_WORDS; k++) begin
                win[k] <= '0;
            end
        end else if (load_en || expnd_en) begin
            for (int k = 0; k < SM3_BLK_WORDS - 1; k++) begin
                win[k] <= win[k+1];
            end
            win[SM3_BLK_WORDS-1] <= load_en ? load_d : w_new;
        end
    end

    assign w0 = win[0];
    assign w4 = win[4];

endmodule

// File: rtl/sm3_expnd.sv
// rtl/sm3_expnd.sv - SM3 message expansion: 16-word load, 64 (W_j, W'_j) round pairs
module sm3_expnd
    import sm3_pkg::*;
#(
    parameter int WORD_DW   = 32,
    parameter int BLK_WORDS = SM3_BLK_WORDS,
    parameter int ROUNDS    = SM3_ROUNDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_DW-1:0]        pad_otpt_d_i,
    input  logic                      pad_otpt_vld_i,
    input  logic                      pad_otpt_lst_i,
    output logic                      pad_otpt_ena_o,
    output logic [WORD_DW-1:0]        expnd_otpt_wj_o,
    output logic [WORD_DW-1:0]        expnd_otpt_wjj_o,
    output logic [$clog2(ROUNDS)-1:0] expnd_otpt_idx_o,
    output logic                      expnd_otpt_vld_o,
    output logic                      expnd_otpt_lst_o,
    input  logic                      expnd_otpt_ena_i,
    output logic                      expnd_err_o
);

    localparam int WCW = $clog2(BLK_WORDS);
    localparam int RCW = $clog2(ROUNDS);
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(BLK_WORDS - 1);
    localparam logic [RCW-1:0] LAST_ROUND = RCW'(ROUNDS - 1);

    expnd_st_t      state, state_nxt;
    logic [WCW-1:0] word_cnt;
    logic [RCW-1:0] round_cnt;
    logic           msg_lst;
    logic           err;
    logic           load_acc;
    logic           round_adv;
    logic [31:0]    w0, w4;

    assign load_acc  = (state == LOAD) && pad_otpt_vld_i;
    assign round_adv = (state == EXPND) && expnd_otpt_ena_i;

    sm3_expnd_win u_win (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_acc),
        .load_d   (pad_otpt_d_i),
        .expnd_en (round_adv),
        .w0       (w0),
        .w4       (w4)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:  if (load_acc && word_cnt == LAST_WORD) state_nxt = EXPND;
            EXPND: if (round_adv && round_cnt == LAST_ROUND) state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            word_cnt  <= '0;
            round_cnt <= '0;
            msg_lst   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_acc) begin
                if (word_cnt == LAST_WORD) begin
                    word_cnt <= '0;
                    msg_lst  <= pad_otpt_lst_i;
                end else begin
                    word_cnt <= word_cnt + WCW'(1);
                    // early last-word marker is a pad-stage protocol fault; the word still loads
                    if (pad_otpt_lst_i) err <= 1'b1;
                end
            end
            if (round_adv) begin
                if (round_cnt == LAST_ROUND) begin
                    round_cnt <= '0;
                    msg_lst   <= 1'b0;
                end else begin
                    round_cnt <= round_cnt + RCW'(1);
                end
            end
        end
    end

    assign pad_otpt_ena_o   = (state == LOAD);
    assign expnd_otpt_vld_o = (state == EXPND);
    assign expnd_otpt_wj_o  = w0;
    assign expnd_otpt_wjj_o = w0 ^ w4;
    assign expnd_otpt_idx_o = round_cnt;
    assign expnd_otpt_lst_o = msg_lst && (round_cnt == LAST_ROUND);
    assign expnd_err_o      = err;

endmodule

// File: doc/sm3_expnd.md
# sm3_expnd

Message-expansion stage of the SM3 core, directly downstream of the padding stage. Accepts the padded message as 32-bit big-endian words, 16 words per 512-bit block. For each block it emits the 64 round pairs (W_j, W'_j) for j = 0..63 to the compression stage, one pair per accepted handshake. A 16-word sliding window generates W_16..W_67 on the fly.

## Interface
Parameters:
- `WORD_DW`, default 32: word width; only 32 is legal (matches the `INPT_DW` = 32 configuration).
- `BLK_WORDS`, default 16: words per block; fixed.
- `ROUNDS`, default 64: rounds per block; fixed.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pad_otpt_d_i`  in  32  padded word from the pad stage.
- `pad_otpt_vld_i`  in  1  word valid.
- `pad_otpt_lst_i`  in  1  word is the last word of the last block of the message.
- `pad_otpt_ena_o`  out  1  ready/enable to the pad stage.
- `expnd_otpt_wj_o`  out  32  W_j.
- `expnd_otpt_wjj_o`  out  32  W'_j = W_j ^ W_{j+4}.
- `expnd_otpt_idx_o`  out  6  round index j.
- `expnd_otpt_vld_o`  out  1  round pair valid.
- `expnd_otpt_lst_o`  out  1  j = 63 of the message's last block.
- `expnd_otpt_ena_i`  in  1  compression stage ready.
- `expnd_err_o`  out  1  sticky protocol error.

## Operation
- States: LOAD, EXPND.
- LOAD
  - `pad_otpt_ena_o` = 1, `expnd_otpt_vld_o` = 0.
  - Word accepted when `pad_otpt_vld_i` & `pad_otpt_ena_o`.
  - Accepted word shifts into window slot w[15] (w[k] ← w[k+1]); word counter increments.
  - On the 16th accept (counter = 15): latch `pad_otpt_lst_i` into `msg_lst`, clear the counter, go to EXPND.
- EXPND
  - `pad_otpt_ena_o` = 0, `expnd_otpt_vld_o` = 1.
  - Outputs: `wj` = w[0], `wjj` = w[0] ^ w[4], `idx` = round counter, `lst` = `msg_lst` & (idx = 63).
  - Round advances when `expnd_otpt_ena_i` = 1: window shifts left; w[15] ← P1(w[0] ^ w[7] ^ (w[13]<<<15)) ^ (w[3]<<<7) ^ w[10], where P1(X) = X ^ (X<<<15) ^ (X<<<23) and <<< is 32-bit rotate.
  - All arithmetic is 32-bit XOR/rotate, with no carries.
  - After the idx = 63 transfer: go to LOAD, clear the round counter, clear `msg_lst`.
- Protocol errors
  - `pad_otpt_lst_i` = 1 on an accepted word with counter ≠ 15 sets `expnd_err_o`.
  - That `lst` is otherwise ignored; loading continues normally.
  - `expnd_err_o` is cleared only by `rst`.
- `pad_otpt_vld_i` while `pad_otpt_ena_o` = 0: not consumed; the pad stage holds its word.

## Timing
- Reset values: state LOAD, counters 0, window all 0, `msg_lst` 0.
  - Outputs after reset: `pad_otpt_ena_o` = 1, `expnd_otpt_vld_o` = 0, `wj` = `wjj` = 0, `idx` = 0, `lst` = 0, `expnd_err_o` = 0.
- 16th word accepted at edge N: `expnd_otpt_vld_o` = 1 with W_0 from cycle N+1.
- Unstalled block: 16 load cycles + 64 round cycles = 80 cycles per block. `pad_otpt_ena_o` returns to 1 the cycle after the j = 63 transfer.
- Stall (`expnd_otpt_ena_i` = 0): every output holds stable; vld stays 1.
- Outputs are combinational decodes of registered state and window only; there is no input-to-output combinational path.
- `rst` mid-block, in either state: aborts the block and returns to reset values on the next edge. A partial block is discarded.

## Structure
- Shared package `sm3_pkg`:
  - state enum `expnd_st_t` {LOAD, EXPND}
  - constants `SM3_BLK_WORDS` = 16 and `SM3_ROUNDS` = 64
  - functions `sm3_rotl32` and `sm3_p1`, shared with the compression stage.
- One natural sub-module: `sm3_expnd_win`, the 16×32 window holding a load-shift port and an expand-shift port.
- The FSM, counters and error flag stay in `sm3_expnd`.

## Test plan
- "abc" single block (0x61626380, 0×14, 0x00000018, lst on word 15)
  - first pair: j = 0, W = 0x61626380, W' = 0x61626380
  - j = 15: W = 0x00000018
  - j = 16: W = 0x9092E200
  - j = 63: `lst` = 1
  - `pad_otpt_ena_o` returns to 1 at cycle 81.
- Random stalls on `expnd_otpt_ena_i` during the same block → identical W/W' sequence, no dropped or duplicated idx, outputs stable while stalled.
- Two back-to-back blocks with lst only on block 2 word 15:
  - block 1 idx 63 has `lst` = 0, block 2 idx 63 has `lst` = 1
  - block 2 W_j matches a software model.
- Gaps in `pad_otpt_vld_i` during LOAD → correct word ordering. vld held during EXPND is not consumed until LOAD.
- lst asserted on word 5 → `expnd_err_o` = 1 from the next cycle and sticky; expansion output still matches the model.
- `rst` asserted at word 9, and separately at round 30 → all outputs at reset values next cycle; a following full block expands correctly.
